tictactoe_renderer: RTL

- Consumes the game state produced by `gameManager`: both player grids, cursor position and game state.
- Generates a 640x480@60 Hz VGA raster showing the 3x3 board, X/O glyphs, the cursor box and a game-state border.
- Sits between `gameManager` and the board's VGA connector, replacing the stand-alone pattern generator.
- Inputs are snapshotted once per frame, so a frame never shows a half-updated board.

---
 rtl/tictactoe_pkg.sv | 74 +++++++
 rtl/tictactoe_renderer_timing.sv | 51 +++++
 rtl/tictactoe_renderer.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/tictactoe_pkg.sv
// Shared definitions for the tic-tac-toe VGA renderer: 640x480@60 Hz timing,
// colours, game-state encodings and the cell-glyph geometry (for 120 px cells).
package tictactoe_pkg;

    // Horizontal timing, in pixel clocks
    localparam logic [9:0] H_ACTIVE     = 10'd640;
    localparam logic [9:0] H_FP         = 10'd16;
    localparam logic [9:0] H_SYNC       = 10'd96;
    localparam logic [9:0] H_BP         = 10'd48;
    localparam logic [9:0] H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam logic [9:0] H_SYNC_START = H_ACTIVE + H_FP;
    localparam logic [9:0] H_SYNC_END   = H_ACTIVE + H_FP + H_SYNC;

    // Vertical timing, in lines
    localparam logic [9:0] V_ACTIVE     = 10'd480;
    localparam logic [9:0] V_FP         = 10'd10;
    localparam logic [9:0] V_SYNC       = 10'd2;
    localparam logic [9:0] V_BP         = 10'd33;
    localparam logic [9:0] V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [9:0] V_SYNC_START = V_ACTIVE + V_FP;
    localparam logic [9:0] V_SYNC_END   = V_ACTIVE + V_FP + V_SYNC;

    typedef enum logic [2:0] {
        P1_TURN = 3'd0,
        P2_TURN = 3'd1,
        DRAW    = 3'd2,
        P1_WIN  = 3'd3,
        P2_WIN  = 3'd4
    } game_state_t;

    localparam logic [1:0] NO_CURSOR = 2'd3;

    typedef struct packed {
        logic [2:0] red;
        logic [2:0] green;
        logic [1:0] blue;
    } rgb_t;

    localparam rgb_t COL_BLACK  = '{red: 3'b000, green: 3'b000, blue: 2'b00};
    localparam rgb_t COL_WHITE  = '{red: 3'b111, green: 3'b111, blue: 2'b11};
    localparam rgb_t COL_RED    = '{red: 3'b111, green: 3'b000, blue: 2'b00};
    localparam rgb_t COL_BLUE   = '{red: 3'b000, green: 3'b000, blue: 2'b11};
    localparam rgb_t COL_YELLOW = '{red: 3'b111, green: 3'b111, blue: 2'b00};

    // Width of the game-state ring drawn just outside the board
    localparam logic [9:0] BORDER_W = 10'd8;

    // Glyph geometry, as offsets inside a 120 px cell
    localparam logic [6:0] CUR_OUT_LO = 7'd4;
    localparam logic [6:0] CUR_OUT_HI = 7'd115;
    localparam logic [6:0] CUR_IN_LO  = 7'd7;
    localparam logic [6:0] CUR_IN_HI  = 7'd112;
    localparam logic [6:0] X_LO       = 7'd16;
    localparam logic [6:0] X_HI       = 7'd103;
    localparam logic [6:0] X_TOL      = 7'd2;
    localparam logic [7:0] X_ANTI_LO  = 8'd117;   // dx+dy within 119 +/- 2
    localparam logic [7:0] X_ANTI_HI  = 8'd121;
    localparam logic [6:0] O_OUT_LO   = 7'd20;
    localparam logic [6:0] O_OUT_HI   = 7'd99;
    localparam logic [6:0] O_IN_LO    = 7'd26;
    localparam logic [6:0] O_IN_HI    = 7'd93;

    // Undefined encodings 5..7 behave as a draw
    function automatic game_state_t norm_state(input logic [2:0] gs);
        return (gs > 3'd4) ? DRAW : game_state_t'(gs);
    endfunction

    // True when both offsets lie in [lo, hi]
    function automatic logic in_box(input logic [6:0] dx, input logic [6:0] dy,
                                    input logic [6:0] lo, input logic [6:0] hi);
        return (dx >= lo) && (dx <= hi) && (dy >= lo) && (dy <= hi);
    endfunction

endpackage

// File: rtl/tictactoe_renderer_timing.sv
// 640x480@60 Hz raster counters with raw (unregistered-decode) syncs, the
// active-video flag and a registered strobe that is high while the counters
// sit at hcnt=0, vcnt=480 (start of vertical blanking).
module vga_timing_gen
    import tictactoe_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    output logic [9:0] hcnt,
    output logic [9:0] vcnt,
    output logic       active,
    output logic       hsync_raw,
    output logic       vsync_raw,
    output logic       snap_strobe
);

    logic [9:0] hcnt_reg, vcnt_reg;
    logic [9:0] hcnt_next, vcnt_next;
    logic       snap_reg;

    // Next raster position: wrap the pixel counter per line, the line counter per frame
    always_comb begin
        hcnt_next = hcnt_reg + 10'd1;
        vcnt_next = vcnt_reg;
        if (hcnt_reg == H_TOTAL - 10'd1) begin
            hcnt_next = 10'd0;
            vcnt_next = (vcnt_reg == V_TOTAL - 10'd1) ? 10'd0 : vcnt_reg + 10'd1;
        end
    end

    // Counter registers; the strobe is computed one cycle ahead so it is a clean flop
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hcnt_reg <= 10'd0;
            vcnt_reg <= 10'd0;
            snap_reg <= 1'b0;
        end else begin
            hcnt_reg <= hcnt_next;
            vcnt_reg <= vcnt_next;
            snap_reg <= (hcnt_next == 10'd0) && (vcnt_next == V_ACTIVE);
        end
    end

    assign hcnt        = hcnt_reg;
    assign vcnt        = vcnt_reg;
    assign active      = (hcnt_reg < H_ACTIVE) && (vcnt_reg < V_ACTIVE);
    assign hsync_raw   = !((hcnt_reg >= H_SYNC_START) && (hcnt_reg < H_SYNC_END));
    assign vsync_raw   = !((vcnt_reg >= V_SYNC_START) && (vcnt_reg < V_SYNC_END));
    assign snap_strobe = snap_reg;

endmodule

// File: rtl/tictactoe_renderer.sv
// Tic-tac-toe VGA renderer: snapshots the game state once per frame and draws
// board grid, X/O glyphs, cursor box and a game-state ring. Pipeline is
// counters -> stage 1 (cell decode) -> stage 2 (colour + sync), so every
// output trails the counters by two clocks.
// Build option: define TTT_CURSOR_BLINK_EN to blink the cursor every 16 frames.
module tictactoe_renderer
    import tictactoe_pkg::*;
#(
    parameter logic [9:0] BOARD_X0 = 10'd140,
    parameter logic [9:0] BOARD_Y0 = 10'd60,
    parameter logic [9:0] CELL     = 10'd120,
    parameter logic [9:0] LINE_W   = 10'd4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [0:8] p1Grid,
    input  logic [0:8] p2Grid,
    input  logic [3:0] cursorPosition,
    input  logic [2:0] gameState,
    output logic [2:0] vgaRed,
    output logic [2:0] vgaGreen,
    output logic [1:0] vgaBlue,
    output logic       Hsync,
    output logic       Vsync,
    output logic       frame_start
);

    localparam logic [9:0] CELL2   = 10'(2 * CELL);
    localparam logic [9:0] BOARD_W = 10'(3 * CELL);

    logic [9:0] hcnt, vcnt;
    logic       active, hsync_raw, vsync_raw, snap_strobe;

    vga_timing_gen u_timing (
        .clk         (clk),
        .rst         (rst),
        .hcnt        (hcnt),
        .vcnt        (vcnt),
        .active      (active),
        .hsync_raw   (hsync_raw),
        .vsync_raw   (vsync_raw),
        .snap_strobe (snap_strobe)
    );

    // ---------------- per-frame shadow of the game state ----------------
    logic [0:8]  p1_shadow_reg, p2_shadow_reg;
    logic [1:0]  cur_col_reg, cur_row_reg;
    game_state_t state_reg;
    logic [5:0]  frame_cnt_reg;

    // Capture inputs only at the blanking strobe so a frame never mixes two boards
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            p1_shadow_reg <= '0;
            p2_shadow_reg <= '0;
            cur_col_reg   <= 2'd0;
            cur_row_reg   <= 2'd0;
            state_reg     <= P1_TURN;
            frame_cnt_reg <= 6'd0;
        end else if (snap_strobe) begin
            p1_shadow_reg <= p1Grid;
            p2_shadow_reg <= p2Grid;
            cur_col_reg   <= cursorPosition[3:2];
            cur_row_reg   <= cursorPosition[1:0];
            state_reg     <= norm_state(gameState);
            frame_cnt_reg <= frame_cnt_reg + 6'd1;
        end
    end

    // ---------------- stage 1: per-axis cell decode ----------------
    // Index 0 is the horizontal axis, index 1 the vertical axis.
    logic [1:0]      axis_in, axis_ring, axis_grid;
    logic [1:0][1:0] axis_idx;
    logic [1:0][6:0] axis_d;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_axis
            localparam logic [9:0] ORG = (gi == 0) ? BOARD_X0 : BOARD_Y0;
            logic [9:0] pos, off;
            assign pos = (gi == 0) ? hcnt : vcnt;
            assign off = pos - ORG;
            assign axis_in[gi]   = (pos >= ORG) && (pos < ORG + BOARD_W);
            assign axis_ring[gi] = (pos >= ORG - BORDER_W) && (pos < ORG + BOARD_W + BORDER_W);
            // Compare-and-subtract instead of dividing by the cell size
            assign axis_idx[gi]  = (off >= CELL2) ? 2'd2 : ((off >= CELL) ? 2'd1 : 2'd0);
            assign axis_d[gi]    = 7'((off >= CELL2) ? off - CELL2 : ((off >= CELL) ? off - CELL : off));
            assign axis_grid[gi] = ((off >= CELL)  && (off < CELL + LINE_W)) ||
                                   ((off >= CELL2) && (off < CELL2 + LINE_W));
        end
    endgenerate

    logic       s1_active, s1_hsync, s1_vsync;
    logic       s1_in_board, s1_grid, s1_ring;
    logic [1:0] s1_col, s1_row;
    logic [6:0] s1_dx, s1_dy;

    // Register the decoded position so stage 2 only has to pick a colour
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_active   <= 1'b0;
            s1_hsync    <= 1'b1;
            s1_vsync    <= 1'b1;
            s1_in_board <= 1'b0;
            s1_grid     <= 1'b0;
            s1_ring     <= 1'b0;
            s1_col      <= 2'd0;
            s1_row      <= 2'd0;
            s1_dx       <= 7'd0;
            s1_dy       <= 7'd0;
        end else begin
            s1_active   <= active;
            s1_hsync    <= hsync_raw;
            s1_vsync    <= vsync_raw;
            s1_in_board <= axis_in[0] && axis_in[1];
            s1_grid     <= axis_in[0] && axis_in[1] && (axis_grid[0] || axis_grid[1]);
            s1_ring     <= axis_ring[0] && axis_ring[1] && !(axis_in[0] && axis_in[1]);
            s1_col      <= axis_idx[0];
            s1_row      <= axis_idx[1];
            s1_dx       <= axis_d[0];
            s1_dy       <= axis_d[1];
        end
    end

    // ---------------- stage 2: layer priority and colour ----------------
    logic [3:0] cell_idx;
    logic       has_p1, has_p2, cursor_on, x_on, o_on;
    logic [6:0] diag_diff;
    logic [7:0] diag_sum;
    rgb_t       border_col, rgb_next;

    // Pick the highest-priority layer covering the current pixel
    always_comb begin
        cell_idx  = ({2'b00, s1_row} << 1) + {2'b00, s1_row} + {2'b00, s1_col};
        has_p1    = p1_shadow_reg[cell_idx];
        has_p2    = p2_shadow_reg[cell_idx];
        diag_diff = (s1_dx >= s1_dy) ? (s1_dx - s1_dy) : (s1_dy - s1_dx);
        diag_sum  = {1'b0, s1_dx} + {1'b0, s1_dy};

        cursor_on = (state_reg == P1_TURN || state_reg == P2_TURN) &&
                    (cur_col_reg != NO_CURSOR) && (cur_row_reg != NO_CURSOR) &&
                    (s1_col == cur_col_reg) && (s1_row == cur_row_reg) &&
                    in_box(s1_dx, s1_dy, CUR_OUT_LO, CUR_OUT_HI) &&
                    !in_box(s1_dx, s1_dy, CUR_IN_LO, CUR_IN_HI);
`ifdef TTT_CURSOR_BLINK_EN
        cursor_on = cursor_on && !frame_cnt_reg[4];
`endif
        x_on = has_p1 && in_box(s1_dx, s1_dy, X_LO, X_HI) &&
               ((diag_diff <= X_TOL) || ((diag_sum >= X_ANTI_LO) && (diag_sum <= X_ANTI_HI)));
        // A cell claimed by both players shows only the X
        o_on = has_p2 && !has_p1 && in_box(s1_dx, s1_dy, O_OUT_LO, O_OUT_HI) &&
               !in_box(s1_dx, s1_dy, O_IN_LO, O_IN_HI);

        case (state_reg)
            P1_TURN: border_col = COL_RED;
            P2_TURN: border_col = COL_BLUE;
            P1_WIN:  border_col = frame_cnt_reg[5] ? COL_BLACK : COL_RED;
            P2_WIN:  border_col = frame_cnt_reg[5] ? COL_BLACK : COL_BLUE;
            default: border_col = COL_WHITE;
        endcase

        rgb_next = COL_BLACK;
        if (!s1_active)                    rgb_next = COL_BLACK;
        else if (s1_in_board && cursor_on) rgb_next = COL_YELLOW;
        else if (s1_in_board && x_on)      rgb_next = COL_RED;
        else if (s1_in_board && o_on)      rgb_next = COL_BLUE;
        else if (s1_grid)                  rgb_next = COL_WHITE;
        else if (s1_ring)                  rgb_next = border_col;
    end

    rgb_t rgb_reg;
    logic hsync_reg, vsync_reg;

    // Output flops keep colour and syncs on the same clock edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rgb_reg   <= COL_BLACK;
            hsync_reg <= 1'b1;
            vsync_reg <= 1'b1;
        end else begin
            rgb_reg   <= rgb_next;
            hsync_reg <= s1_hsync;
            vsync_reg <= s1_vsync;
        end
    end

    assign vgaRed      = rgb_reg.red;
    assign vgaGreen    = rgb_reg.green;
    assign vgaBlue     = rgb_reg.blue;
    assign Hsync       = hsync_reg;
    assign Vsync       = vsync_reg;
    assign frame_start = snap_strobe;

endmodule
